issue_age_scheduler: RTL and testbench

// Oldest-first select scheduler for the 16-entry out-of-order issue queue. Tracks slot occupancy and

---
 rtl/issue_age_scheduler_if.sv | 28 ++
 rtl/issue_age_scheduler.sv | 142 ++++++++++++++
 tb/tb_issue_age_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/issue_age_scheduler_if.sv
// Handshake bundle between rename, issue-queue wakeup, execute and the age scheduler.
// The master side drives allocation, readiness and accept; the slave side is the scheduler.
interface issue_age_scheduler_if #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
);
    logic               alloc_valid;
    logic [IDX_W-1:0]   alloc_idx;
    logic [ENTRIES-1:0] ready_vec;
    logic               exe_accept;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               free_valid;
    logic [IDX_W-1:0]   free_idx;
    logic               full;
    logic [IDX_W:0]     occ_cnt;
    logic               alloc_overflow;

    modport master (
        output alloc_valid, alloc_idx, ready_vec, exe_accept,
        input  grant_valid, grant_idx, free_valid, free_idx, full, occ_cnt, alloc_overflow
    );

    modport slave (
        input  alloc_valid, alloc_idx, ready_vec, exe_accept,
        output grant_valid, grant_idx, free_valid, free_idx, full, occ_cnt, alloc_overflow
    );
endinterface

// File: rtl/issue_age_scheduler.sv
// Oldest-first select for a 16-slot issue queue: occupancy bits, an age matrix,
// lowest-free-slot allocation and a registered grant held until execute accepts it.
module issue_age_scheduler #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  STALL,
    input  logic                  FLUSH,
    issue_age_scheduler_if.slave  io
);

    logic [ENTRIES-1:0]              valid_q,  valid_d;
    logic [ENTRIES-1:0][ENTRIES-1:0] older_q,  older_d;
    logic                            grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]                grant_idx_q,   grant_idx_d;
    logic [IDX_W:0]                  occ_cnt_q,     occ_cnt_d;
    logic                            overflow_q,    overflow_d;

    logic [ENTRIES-1:0] pend_mask;
    logic [ENTRIES-1:0] acc_mask;
    logic [ENTRIES-1:0] alloc_mask;
    logic [ENTRIES-1:0] cand;
    logic [ENTRIES-1:0] oldest_sel;
    logic [ENTRIES-1:0] valid_post;
    logic [IDX_W-1:0]   oldest_idx;
    logic [IDX_W-1:0]   free_idx_c;
    logic               full_c;
    logic               accept;
    logic               alloc_legal;
    logic               alloc_bad;

    assign full_c      = &valid_q;
    assign accept      = grant_valid_q & io.exe_accept;
    assign alloc_legal = io.alloc_valid & ~full_c & ~valid_q[io.alloc_idx];
    assign alloc_bad   = io.alloc_valid & ~alloc_legal;

    always_comb begin
        free_idx_c = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx_c = IDX_W'(i);
        end
    end

    // The presented grant is never a candidate: it is either held or being consumed this edge.
    always_comb begin
        pend_mask  = '0;
        acc_mask   = '0;
        alloc_mask = '0;
        if (grant_valid_q) pend_mask[grant_idx_q] = 1'b1;
        if (accept)        acc_mask[grant_idx_q]  = 1'b1;
        if (alloc_legal)   alloc_mask[io.alloc_idx] = 1'b1;
        cand       = valid_q & io.ready_vec & ~pend_mask;
        valid_post = valid_q & ~acc_mask;
    end

    always_comb begin
        logic blocked;
        oldest_sel = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
                if (cand[j] && older_q[j][i]) blocked = 1'b1;
            end
            oldest_sel[i] = cand[i] & ~blocked;
        end
    end

    always_comb begin
        oldest_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (oldest_sel[i]) oldest_idx = IDX_W'(i);
        end
    end

    always_comb begin
        valid_d       = valid_q;
        older_d       = older_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        occ_cnt_d     = occ_cnt_q;
        overflow_d    = overflow_q;

        if (FLUSH) begin
            valid_d       = '0;
            older_d       = '0;
            grant_valid_d = 1'b0;
            occ_cnt_d     = '0;
        end else if (!STALL) begin
            // Retire the accepted slot first so a same-edge alloc sees the post-accept occupancy.
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (acc_mask[i] || acc_mask[j]) older_d[i][j] = 1'b0;
                end
            end
            valid_d = valid_post | alloc_mask;

            if (alloc_legal) begin
                for (int k = 0; k < ENTRIES; k++) begin
                    older_d[k][io.alloc_idx] = valid_post[k];
                end
                older_d[io.alloc_idx] = '0;
            end

            overflow_d = overflow_q | alloc_bad;
            occ_cnt_d  = occ_cnt_q + (IDX_W + 1)'(alloc_legal) - (IDX_W + 1)'(accept);

            if (!grant_valid_q || io.exe_accept) begin
                grant_valid_d = |cand;
                grant_idx_d   = oldest_idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q       <= '0;
            older_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            occ_cnt_q     <= '0;
            overflow_q    <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            older_q       <= older_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            occ_cnt_q     <= occ_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    assign io.grant_valid    = grant_valid_q;
    assign io.grant_idx      = grant_idx_q;
    assign io.free_valid     = ~full_c;
    assign io.free_idx       = free_idx_c;
    assign io.full           = full_c;
    assign io.occ_cnt        = occ_cnt_q;
    assign io.alloc_overflow = overflow_q;

endmodule

// File: tb/tb_issue_age_scheduler.sv
// Directed bench for issue_age_scheduler: allocation order, oldest-first grant,
// grant hold, full/overflow, flush, stall and asynchronous reset.
module tb_issue_age_scheduler;

    logic CLK = 1'b0;
    logic RESET;
    logic STALL;
    logic FLUSH;
    int   checks = 0;
    int   errors = 0;

    issue_age_scheduler_if #(.ENTRIES(16), .IDX_W(4)) io ();

    issue_age_scheduler #(.ENTRIES(16), .IDX_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .STALL (STALL),
        .FLUSH (FLUSH),
        .io    (io)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        STALL = 0; FLUSH = 0;
        io.alloc_valid = 0; io.alloc_idx = 0; io.ready_vec = 0; io.exe_accept = 0;
        RESET = 1;
        step();
        RESET = 0;
        #1;
    endtask

    task automatic alloc_one(input int idx);
        io.alloc_valid = 1;
        io.alloc_idx   = 4'(idx);
        step();
        io.alloc_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (io.free_valid !== 1'b1) begin errors++; $display("FAIL rst_free_valid got %0d exp 1", io.free_valid); end
        checks++; if (io.free_idx !== 4'd0) begin errors++; $display("FAIL rst_free_idx got %0d exp 0", io.free_idx); end
        checks++; if (io.full !== 1'b0) begin errors++; $display("FAIL rst_full got %0d exp 0", io.full); end
        checks++; if (io.occ_cnt !== 5'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", io.occ_cnt); end
        checks++; if (io.grant_valid !== 1'b0 || io.grant_idx !== 4'd0) begin errors++; $display("FAIL rst_grant got v%0d i%0d exp v0 i0", io.grant_valid, io.grant_idx); end
        checks++; if (io.alloc_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0d exp 0", io.alloc_overflow); end
        io.ready_vec = 16'hFFFF;
        step();
        io.ready_vec = 16'h0000;
        checks++; if (io.grant_valid !== 1'b0) begin errors++; $display("FAIL ready_on_empty got %0d exp 0", io.grant_valid); end
    endtask

    task automatic test_alloc_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_one(i);
            checks++; if (io.free_idx !== 4'(i + 1)) begin errors++; $display("FAIL alloc_free_idx%0d got %0d exp %0d", i, io.free_idx, i + 1); end
        end
        checks++; if (io.occ_cnt !== 5'd3) begin errors++; $display("FAIL alloc_occ got %0d exp 3", io.occ_cnt); end
        checks++; if (io.grant_valid !== 1'b0) begin errors++; $display("FAIL alloc_no_grant got %0d exp 0", io.grant_valid); end
    endtask

    task automatic test_oldest_first();
        logic [3:0] exp_idx [3];
        exp_idx[0] = 4'd5; exp_idx[1] = 4'd2; exp_idx[2] = 4'd9;
        do_reset();
        alloc_one(5);
        alloc_one(2);
        alloc_one(9);
        io.ready_vec = 16'hFFFF;
        io.exe_accept = 1;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++; if (io.grant_valid !== 1'b1 || io.grant_idx !== exp_idx[n]) begin errors++; $display("FAIL age_grant%0d got v%0d i%0d exp v1 i%0d", n, io.grant_valid, io.grant_idx, exp_idx[n]); end
        end
        checks++; if (io.occ_cnt !== 5'd1) begin errors++; $display("FAIL age_occ_mid got %0d exp 1", io.occ_cnt); end
        step();
        checks++; if (io.grant_valid !== 1'b0) begin errors++; $display("FAIL age_drain_valid got %0d exp 0", io.grant_valid); end
        checks++; if (io.occ_cnt !== 5'd0) begin errors++; $display("FAIL age_drain_occ got %0d exp 0", io.occ_cnt); end
        io.exe_accept = 0;
        io.ready_vec = 0;
    endtask

    task automatic test_grant_hold();
        do_reset();
        alloc_one(1);
        alloc_one(3);
        io.ready_vec = 16'h0008;
        step();
        checks++; if (io.grant_valid !== 1'b1 || io.grant_idx !== 4'd3) begin errors++; $display("FAIL hold_first got v%0d i%0d exp v1 i3", io.grant_valid, io.grant_idx); end
        io.ready_vec = 16'h000A;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++; if (io.grant_valid !== 1'b1 || io.grant_idx !== 4'd3) begin errors++; $display("FAIL hold_cyc%0d got v%0d i%0d exp v1 i3", n, io.grant_valid, io.grant_idx); end
        end
        io.exe_accept = 1;
        step();
        io.exe_accept = 0;
        checks++; if (io.grant_valid !== 1'b1 || io.grant_idx !== 4'd1) begin errors++; $display("FAIL hold_after_accept got v%0d i%0d exp v1 i1", io.grant_valid, io.grant_idx); end
        checks++; if (io.occ_cnt !== 5'd1) begin errors++; $display("FAIL hold_occ got %0d exp 1", io.occ_cnt); end
        io.ready_vec = 0;
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            checks++; if (io.free_idx !== 4'(i)) begin errors++; $display("FAIL fill_free_idx%0d got %0d exp %0d", i, io.free_idx, i); end
            alloc_one(i);
        end
        checks++; if (io.full !== 1'b1 || io.free_valid !== 1'b0) begin errors++; $display("FAIL full_flags got full%0d free%0d exp full1 free0", io.full, io.free_valid); end
        checks++; if (io.occ_cnt !== 5'd16) begin errors++; $display("FAIL full_occ got %0d exp 16", io.occ_cnt); end
        alloc_one(3);
        checks++; if (io.alloc_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %0d exp 1", io.alloc_overflow); end
        checks++; if (io.occ_cnt !== 5'd16 || io.full !== 1'b1) begin errors++; $display("FAIL overflow_state got occ%0d full%0d exp occ16 full1", io.occ_cnt, io.full); end
    endtask

    task automatic test_alloc_accept_same_edge();
        do_reset();
        alloc_one(0);
        io.ready_vec = 16'h0001;
        step();
        checks++; if (io.grant_valid !== 1'b1 || io.grant_idx !== 4'd0) begin errors++; $display("FAIL aa_grant got v%0d i%0d exp v1 i0", io.grant_valid, io.grant_idx); end
        io.exe_accept = 1;
        alloc_one(1);
        io.exe_accept = 0;
        checks++; if (io.occ_cnt !== 5'd1) begin errors++; $display("FAIL aa_occ got %0d exp 1", io.occ_cnt); end
        checks++; if (io.free_idx !== 4'd0) begin errors++; $display("FAIL aa_free_idx got %0d exp 0", io.free_idx); end
        checks++; if (io.grant_valid !== 1'b0) begin errors++; $display("FAIL aa_grant_valid got %0d exp 0", io.grant_valid); end
        io.ready_vec = 0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 7; i++) alloc_one(i);
        io.ready_vec = 16'hFFFF;
        step();
        alloc_one(0);
        checks++; if (io.grant_valid !== 1'b1 || io.occ_cnt !== 5'd7) begin errors++; $display("FAIL preflush got v%0d occ%0d exp v1 occ7", io.grant_valid, io.occ_cnt); end
        checks++; if (io.alloc_overflow !== 1'b1) begin errors++; $display("FAIL preflush_overflow got %0d exp 1", io.alloc_overflow); end
        FLUSH = 1;
        io.alloc_valid = 1; io.alloc_idx = 4'd7; io.exe_accept = 1;
        step();
        FLUSH = 0;
        io.alloc_valid = 0; io.exe_accept = 0; io.ready_vec = 0;
        checks++; if (io.grant_valid !== 1'b0) begin errors++; $display("FAIL flush_grant got %0d exp 0", io.grant_valid); end
        checks++; if (io.occ_cnt !== 5'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", io.occ_cnt); end
        checks++; if (io.free_idx !== 4'd0 || io.free_valid !== 1'b1) begin errors++; $display("FAIL flush_free got i%0d v%0d exp i0 v1", io.free_idx, io.free_valid); end
        checks++; if (io.alloc_overflow !== 1'b1) begin errors++; $display("FAIL flush_keeps_overflow got %0d exp 1", io.alloc_overflow); end
    endtask

    task automatic test_stall_reset();
        do_reset();
        alloc_one(0);
        alloc_one(1);
        io.ready_vec = 16'hFFFF;
        step();
        STALL = 1;
        io.exe_accept = 1;
        io.alloc_valid = 1; io.alloc_idx = 4'd2;
        step();
        step();
        checks++; if (io.occ_cnt !== 5'd2) begin errors++; $display("FAIL stall_occ got %0d exp 2", io.occ_cnt); end
        checks++; if (io.grant_valid !== 1'b1 || io.grant_idx !== 4'd0) begin errors++; $display("FAIL stall_grant got v%0d i%0d exp v1 i0", io.grant_valid, io.grant_idx); end
        checks++; if (io.free_idx !== 4'd2) begin errors++; $display("FAIL stall_free_idx got %0d exp 2", io.free_idx); end
        #2;
        RESET = 1;
        #1;
        checks++; if (io.grant_valid !== 1'b0 || io.grant_idx !== 4'd0) begin errors++; $display("FAIL async_rst_grant got v%0d i%0d exp v0 i0", io.grant_valid, io.grant_idx); end
        checks++; if (io.occ_cnt !== 5'd0 || io.free_idx !== 4'd0 || io.free_valid !== 1'b1) begin errors++; $display("FAIL async_rst_occ got occ%0d free%0d fv%0d exp 0 0 1", io.occ_cnt, io.free_idx, io.free_valid); end
        step();
        RESET = 0;
        STALL = 0;
        io.exe_accept = 0; io.alloc_valid = 0; io.ready_vec = 0;
    endtask

    initial begin
        test_reset();
        test_alloc_order();
        test_oldest_first();
        test_grant_hold();
        test_full_overflow();
        test_alloc_accept_same_edge();
        test_flush();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
